// File: rtl/urx_pkg.sv
// urx_pkg: shared FSM states, error codes and defaults
// for the URX frame parser slice.
package urx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CHK
  } st_t;

  localparam logic [1:0] ERR_TO   = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_ROOM = 2'd2;
  localparam logic [1:0] ERR_CHK  = 2'd3;

  localparam logic [7:0] SYNC_DEF    = 8'hA5;
  localparam int         MAX_LEN_DEF = 8;
  localparam int         DEPTH_DEF   = 16;
  localparam int         TO_CYC_DEF  = 5000;

  function automatic logic [7:0] chk_acc(
    input logic [7:0] acc,
    input logic [7:0] b
  );
    return acc ^ b;
  endfunction

endpackage

// File: rtl/urx_byte_fifo.sv
// urx_byte_fifo: byte RAM with write, commit and read pointers;
// readers only see bytes behind the commit pointer.
module urx_byte_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_dat,
  input  logic          commit,
  input  logic          rollback,
  input  logic          rd_en,
  output logic [7:0]    rd_dat,
  output logic          rd_valid,
  output logic [PW-1:0] cnt,
  output logic [PW-1:0] used
);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] cm_ptr;
  logic [PW-1:0] rd_ptr;

  assign rd_valid = (rd_ptr != cm_ptr);
  assign cnt      = cm_ptr - rd_ptr;
  assign used     = wr_ptr - rd_ptr;

  // gated so the port idles at zero while nothing is committed
  assign rd_dat = rd_valid ? mem[rd_ptr[AW-1:0]] : 8'd0;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= wr_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      cm_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (rollback) begin
        wr_ptr <= cm_ptr;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (commit) begin
        cm_ptr <= wr_ptr;
      end
      if (rd_en && rd_valid) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/urx_frame_parser.sv
// urx_frame_parser: delimits SYNC,LEN,payload,CHK frames from the
// byte receiver and serves checksum-verified payload to the consumer.
module urx_frame_parser
  import urx_pkg::*;
#(
  parameter logic [7:0] SYNC    = SYNC_DEF,
  parameter int         MAX_LEN = MAX_LEN_DEF,
  parameter int         DEPTH   = DEPTH_DEF,
  parameter int         TO_CYC  = TO_CYC_DEF,
  localparam int        PW      = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    rx_dat,
  input  logic          rx_stb,
  output logic [7:0]    pl_dat,
  output logic          pl_valid,
  input  logic          pl_rd,
  output logic          frame_ok,
  output logic          frame_err,
  output logic [1:0]    err_code,
  output logic          busy,
  output logic [PW-1:0] fifo_cnt
);

  localparam int GW = $clog2(TO_CYC + 1);

  st_t           state;
  st_t           state_nxt;
  logic [7:0]    chk;
  logic [7:0]    rem;
  logic [GW-1:0] gap;
  logic [PW-1:0] used;
  logic [8:0]    room;
  logic          timeout;
  logic          pop;
  logic          len_bad;
  logic          no_room;
  logic          wr_en;
  logic          commit;
  logic          rollback;
  logic          load;
  logic          ok_set;
  logic          err_set;
  logic [1:0]    err_val;

  assign busy    = (state != ST_IDLE);
  assign timeout = busy && (gap == GW'(TO_CYC));
  assign pop     = pl_rd && pl_valid;

  // a pop on the LEN edge frees its slot in time for this frame
  assign room    = 9'(DEPTH) - 9'(used) + 9'(pop);
  assign len_bad = (rx_dat == 8'd0) || (rx_dat > 8'(MAX_LEN));
  assign no_room = {1'b0, rx_dat} > room;

  urx_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_dat   (rx_dat),
    .commit   (commit),
    .rollback (rollback),
    .rd_en    (pl_rd),
    .rd_dat   (pl_dat),
    .rd_valid (pl_valid),
    .cnt      (fifo_cnt),
    .used     (used)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    commit    = 1'b0;
    rollback  = 1'b0;
    load      = 1'b0;
    ok_set    = 1'b0;
    err_set   = 1'b0;
    err_val   = ERR_TO;
    if (timeout) begin
      rollback  = 1'b1;
      err_set   = 1'b1;
      err_val   = ERR_TO;
      state_nxt = ST_IDLE;
    end else if (rx_stb) begin
      unique case (1'b1)
        (state == ST_IDLE): begin
          if (rx_dat == SYNC) begin
            state_nxt = ST_LEN;
          end
        end
        (state == ST_LEN): begin
          if (len_bad) begin
            err_set   = 1'b1;
            err_val   = ERR_LEN;
            state_nxt = ST_IDLE;
          end else if (no_room) begin
            err_set   = 1'b1;
            err_val   = ERR_ROOM;
            state_nxt = ST_IDLE;
          end else begin
            load      = 1'b1;
            state_nxt = ST_DATA;
          end
        end
        (state == ST_DATA): begin
          wr_en = 1'b1;
          if (rem == 8'd1) begin
            state_nxt = ST_CHK;
          end
        end
        default: begin
          if (rx_dat == chk) begin
            commit = 1'b1;
            ok_set = 1'b1;
          end else begin
            rollback = 1'b1;
            err_set  = 1'b1;
            err_val  = ERR_CHK;
          end
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk       <= 8'd0;
      rem       <= 8'd0;
      gap       <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= ERR_TO;
    end else begin
      frame_ok  <= ok_set;
      frame_err <= err_set;
      if (err_set) begin
        err_code <= err_val;
      end
      if (load) begin
        chk <= rx_dat;
        rem <= rx_dat;
      end else if (wr_en) begin
        chk <= chk_acc(chk, rx_dat);
        rem <= rem - 8'd1;
      end
      if (!busy || rx_stb) begin
        gap <= '0;
      end else begin
        gap <= gap + GW'(1);
      end
    end
  end

endmodule

// File: tb/tb_urx_frame_parser.sv
// tb_urx_frame_parser: queue-based frame model compared every cycle,
// plus directed frames with literal expectations.
module tb_urx_frame_parser;

  localparam logic [7:0] SYNC    = 8'hA5;
  localparam int         MAX_LEN = 8;
  localparam int         DEPTH   = 16;
  localparam int         TO_CYC  = 5000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_dat = 8'd0;
  logic       rx_stb = 1'b0;
  logic       pl_rd = 1'b0;
  logic [7:0] pl_dat;
  logic       pl_valid;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;
  logic [4:0] fifo_cnt;

  always #5 clk = ~clk;

  urx_frame_parser #(
    .SYNC    (SYNC),
    .MAX_LEN (MAX_LEN),
    .DEPTH   (DEPTH),
    .TO_CYC  (TO_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_dat    (rx_dat),
    .rx_stb    (rx_stb),
    .pl_dat    (pl_dat),
    .pl_valid  (pl_valid),
    .pl_rd     (pl_rd),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .busy      (busy),
    .fifo_cnt  (fifo_cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;
  longint cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s cycle %0d: got %0h expected %0h",
               name, cyc, act, exp);
    end
  endtask

  // model: committed bytes, bytes of the open frame, frame position
  logic [7:0] mq[$];
  logic [7:0] fb[$];
  bit         m_in;
  int         m_len;
  longint     last_stb;
  bit         e_ok;
  bit         e_err;
  int         e_code;
  bit         rand_rd = 1'b0;

  task automatic model_reset();
    mq.delete();
    fb.delete();
    m_in   = 1'b0;
    m_len  = -1;
    e_ok   = 1'b0;
    e_err  = 1'b0;
    e_code = 0;
  endtask

  task automatic model_step();
    bit         pop;
    bit         cm;
    logic [7:0] s;
    pop   = pl_rd && (mq.size() > 0);
    cm    = 1'b0;
    e_ok  = 1'b0;
    e_err = 1'b0;
    if (m_in && (cyc - last_stb > TO_CYC)) begin
      fb.delete();
      m_in   = 1'b0;
      e_err  = 1'b1;
      e_code = 0;
    end else if (rx_stb) begin
      last_stb = cyc;
      if (!m_in) begin
        if (rx_dat == SYNC) begin
          m_in  = 1'b1;
          m_len = -1;
        end
      end else if (m_len < 0) begin
        if (rx_dat == 0 || int'(rx_dat) > MAX_LEN) begin
          m_in = 1'b0; e_err = 1'b1; e_code = 1;
        end else if (int'(rx_dat) > DEPTH - mq.size() + int'(pop)) begin
          m_in = 1'b0; e_err = 1'b1; e_code = 2;
        end else begin
          m_len = int'(rx_dat);
          fb.delete();
        end
      end else if (fb.size() < m_len) begin
        fb.push_back(rx_dat);
      end else begin
        s = 8'(m_len);
        foreach (fb[i]) s = s ^ fb[i];
        if (s == rx_dat) begin
          cm = 1'b1;
        end else begin
          e_err = 1'b1; e_code = 3;
        end
        m_in = 1'b0;
      end
    end
    if (pop) void'(mq.pop_front());
    if (cm) begin
      foreach (fb[i]) mq.push_back(fb[i]);
      e_ok = 1'b1;
    end
    if (!m_in) fb.delete();
  endtask

  initial model_reset();

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) model_reset();
    check("frame_ok", int'(frame_ok), int'(e_ok));
    check("frame_err", int'(frame_err), int'(e_err));
    check("err_code", int'(err_code), e_code);
    check("busy", int'(busy), int'(m_in));
    check("fifo_cnt", int'(fifo_cnt), mq.size());
    check("pl_valid", int'(pl_valid), int'(mq.size() > 0));
    if (mq.size() > 0) check("pl_dat", int'(pl_dat), int'(mq[0]));
    if (rst_n) model_step();
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rd) pl_rd = ($urandom_range(0, 2) == 0);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit rd = 1'b0);
    @(posedge clk); #1;
    rx_dat = b;
    rx_stb = 1'b1;
    if (!rand_rd) pl_rd = rd;
    @(posedge clk); #1;
    rx_stb = 1'b0;
    if (!rand_rd) pl_rd = 1'b0;
  endtask

  task automatic pop1();
    @(posedge clk); #1;
    pl_rd = 1'b1;
    @(posedge clk); #1;
    pl_rd = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] pl[$], input bit bad,
                            input int gmax);
    logic [7:0] s;
    s = 8'(pl.size());
    send(SYNC);
    idle($urandom_range(0, gmax));
    send(s);
    foreach (pl[i]) begin
      idle($urandom_range(0, gmax));
      send(pl[i]);
      s = s ^ pl[i];
    end
    idle($urandom_range(0, gmax));
    if (bad) s = s ^ 8'($urandom_range(1, 255));
    send(s);
  endtask

  task automatic rand_frame();
    int         k;
    int         n;
    logic [7:0] b;
    logic [7:0] pl[$];
    k = $urandom_range(0, 9);
    if (k == 8) begin
      repeat ($urandom_range(1, 3)) begin
        do b = 8'($urandom_range(0, 255)); while (b == SYNC);
        send(b);
      end
    end else if (k == 7) begin
      send(SYNC);
      if ($urandom_range(0, 1) == 0) send(8'd0);
      else send(8'($urandom_range(MAX_LEN + 1, 255)));
    end else begin
      n = $urandom_range(1, MAX_LEN);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom_range(0, 255));
        if (k == 9 && i == 0) b = SYNC;
        pl.push_back(b);
      end
      send_frame(pl, k == 6, 2);
    end
  endtask

  logic [7:0] pl7[$];

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst busy", int'(busy), 0);
    check("rst pl_valid", int'(pl_valid), 0);
    check("rst fifo_cnt", int'(fifo_cnt), 0);
    check("rst frame_err", int'(frame_err), 0);

    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    send(8'h03);
    @(negedge clk);
    check("good ok", int'(frame_ok), 1);
    check("good cnt", int'(fifo_cnt), 3);
    check("good d0", int'(pl_dat), 'h11);
    pop1(); @(negedge clk); check("good d1", int'(pl_dat), 'h22);
    pop1(); @(negedge clk); check("good d2", int'(pl_dat), 'h33);
    pop1(); @(negedge clk); check("good empty", int'(pl_valid), 0);

    send(8'hA5); send(8'h02); send(8'hAA); send(8'hBB); send(8'h00);
    @(negedge clk);
    check("badchk err", int'(frame_err), 1);
    check("badchk code", int'(err_code), 3);
    check("badchk cnt", int'(fifo_cnt), 0);

    send(8'hA5); send(8'h00);
    @(negedge clk);
    check("len0 err", int'(frame_err), 1);
    check("len0 code", int'(err_code), 1);
    send(8'hA5); send(8'h09);
    @(negedge clk);
    check("len9 err", int'(frame_err), 1);
    send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
    @(negedge clk);
    check("len1 ok", int'(frame_ok), 1);
    check("len1 dat", int'(pl_dat), 'h7E);
    check("len1 cnt", int'(fifo_cnt), 1);
    pop1();

    send(8'hA5); send(8'h02); send(8'h10);
    idle(TO_CYC + 5);
    @(negedge clk);
    check("to busy", int'(busy), 0);
    check("to code", int'(err_code), 0);
    check("to cnt", int'(fifo_cnt), 0);

    send(8'hA5); send(8'h01);
    idle(TO_CYC - 2);
    send(8'h42); send(8'h43);
    @(negedge clk);
    check("to edge ok", int'(frame_ok), 1);
    check("to edge cnt", int'(fifo_cnt), 1);
    pop1();
    send(8'hA5); send(8'h01);
    idle(TO_CYC - 1);
    send(8'h42);
    @(negedge clk);
    check("to late err", int'(frame_err), 1);
    check("to late busy", int'(busy), 0);

    for (int f = 0; f < 2; f++) begin
      pl7.delete();
      for (int i = 0; i < 7; i++) pl7.push_back(8'($urandom_range(0, 255)));
      send_frame(pl7, 1'b0, 0);
    end
    send(8'hA5); send(8'h03);
    @(negedge clk);
    check("room err", int'(frame_err), 1);
    check("room code", int'(err_code), 2);
    check("room cnt", int'(fifo_cnt), 14);
    pop1();
    send(8'hA5); send(8'h02); send(8'h12); send(8'h34); send(8'h24);
    @(negedge clk);
    check("room15 ok", int'(frame_ok), 1);
    check("room15 cnt", int'(fifo_cnt), 15);
    send(8'hA5); send(8'h02);
    @(negedge clk);
    check("room1 err", int'(frame_err), 1);
    send(8'hA5); send(8'h02, 1'b1); send(8'h56); send(8'h78);
    send(8'h2C, 1'b1);
    @(negedge clk);
    check("popcm ok", int'(frame_ok), 1);
    check("popcm cnt", int'(fifo_cnt), 15);
    repeat (16) pop1();
    @(negedge clk);
    check("drain", int'(pl_valid), 0);

    send(8'h00); send(8'hFF);
    send(8'hA5); send(8'h01); send(8'h5A); send(8'h5B);
    @(negedge clk);
    check("junk ok", int'(frame_ok), 1);
    check("junk dat", int'(pl_dat), 'h5A);

    send(8'hA5); send(8'h03); send(8'h01);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check("mrst cnt", int'(fifo_cnt), 0);
    check("mrst busy", int'(busy), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    send(8'hA5); send(8'h01); send(8'hC3); send(8'hC2);
    @(negedge clk);
    check("post rst ok", int'(frame_ok), 1);
    check("post rst dat", int'(pl_dat), 'hC3);
    pop1();

    rand_rd = 1'b1;
    repeat (300) begin
      rand_frame();
      idle($urandom_range(0, 3));
    end
    rand_rd = 1'b0;
    @(posedge clk); #1 pl_rd = 1'b0;
    send(8'hA5); send(8'h04); send(8'h9C); send(8'h01);
    idle(TO_CYC + 3);
    repeat (18) pop1();
    idle(4);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
